// File: rtl/dram_pkg.sv
// Shared FSM state type and read-latency limits for the dram_banked_rw block.
package dram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dram_banked_rw_if.sv
// Write/read/clear bus of dram_banked_rw; master drives requests, slave returns read data and busy.
interface dram_banked_rw_if #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH = 4
);

    logic                      wen;
    logic [RAM_WIDTH/8-1:0]    wbe;
    logic [RAM_ADDR_WIDTH-1:0] waddr;
    logic [RAM_WIDTH-1:0]      din;
    logic                      ren;
    logic [RAM_ADDR_WIDTH-1:0] raddr;
    logic                      clear;
    logic [RAM_WIDTH-1:0]      dout;
    logic                      dout_valid;
    logic                      busy;

    modport master (
        output wen, wbe, waddr, din, ren, raddr, clear,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  wen, wbe, waddr, din, ren, raddr, clear,
        output dout, dout_valid, busy
    );

endinterface

// File: rtl/dram_core.sv
// Byte-enabled simple dual-port storage array with a one-cycle registered, read-first read port.
module dram_core #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 16,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [RAM_WIDTH/8-1:0]    be,
    input  logic [RAM_ADDR_WIDTH-1:0] waddr,
    input  logic [RAM_WIDTH-1:0]      wdata,
    input  logic                      re,
    input  logic [RAM_ADDR_WIDTH-1:0] raddr,
    output logic [RAM_WIDTH-1:0]      rdata
);

    localparam int NBYTES = RAM_WIDTH / 8;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] rdata_d, rdata_q;
    logic                 wr_ok;
    logic                 rd_ok;

    always_comb begin
        wr_ok = we && (32'(waddr) < 32'(RAM_DEPTH));
        rd_ok = 32'(raddr) < 32'(RAM_DEPTH);
    end

    // The array itself is never reset; only a clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rd_ok ? mem[raddr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dram_banked_rw.sv
// Clearable byte-enabled RAM with 1- or 2-cycle read latency.
// Define DRAM_BYPASS_EN for write-first same-address reads; otherwise reads are read-first.
module dram_banked_rw
    import dram_pkg::*;
#(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 16,
    parameter int RAM_ADDR_WIDTH = 4,
    parameter int RD_LATENCY     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    dram_banked_rw_if.slave  bus
);

    localparam int NBYTES = RAM_WIDTH / 8;
    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);

    if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_latency
        $error("dram_banked_rw: RD_LATENCY must be 1 or 2");
    end

    dram_state_e               state_d, state_q;
    logic [RAM_ADDR_WIDTH-1:0] clr_cnt_d, clr_cnt_q;

    logic                      core_we;
    logic [NBYTES-1:0]         core_be;
    logic [RAM_ADDR_WIDTH-1:0] core_waddr;
    logic [RAM_WIDTH-1:0]      core_wdata;
    logic [RAM_WIDTH-1:0]      core_rdata;
    logic                      rd_acc;
    logic                      busy;
    logic [RAM_WIDTH-1:0]      rd_data1;
    logic                      vld1_d, vld1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            vld1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            vld1_q    <= vld1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                clr_cnt_d = '0;
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + RAM_ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // While sweeping, the core write port belongs to the counter and user requests are dropped.
    always_comb begin
        busy       = 1'b0;
        core_we    = bus.wen;
        core_be    = bus.wbe;
        core_waddr = bus.waddr;
        core_wdata = bus.din;
        rd_acc     = bus.ren;
        if (state_q == ST_CLEAR) begin
            busy       = 1'b1;
            core_we    = 1'b1;
            core_be    = '1;
            core_waddr = clr_cnt_q;
            core_wdata = '0;
            rd_acc     = 1'b0;
        end
        vld1_d = rd_acc;
    end

    dram_core #(
        .RAM_WIDTH      (RAM_WIDTH),
        .RAM_DEPTH      (RAM_DEPTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (core_we),
        .be    (core_be),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_acc),
        .raddr (bus.raddr),
        .rdata (core_rdata)
    );

`ifdef DRAM_BYPASS_EN
    logic                 byp_hit_d, byp_hit_q;
    logic [RAM_WIDTH-1:0] byp_data_d, byp_data_q;
    logic [NBYTES-1:0]    byp_be_d, byp_be_q;

    // Capture the colliding write alongside the read so the merge holds as long as dout does.
    always_comb begin
        byp_hit_d  = byp_hit_q;
        byp_data_d = byp_data_q;
        byp_be_d   = byp_be_q;
        if (rd_acc) begin
            byp_hit_d  = core_we && (core_waddr == bus.raddr) &&
                         (32'(core_waddr) < 32'(RAM_DEPTH));
            byp_data_d = core_wdata;
            byp_be_d   = core_be;
        end
        rd_data1 = core_rdata;
        if (byp_hit_q) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byp_be_q[i]) begin
                    rd_data1[i*8 +: 8] = byp_data_q[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
            byp_be_q   <= byp_be_d;
        end
    end
`else
    assign rd_data1 = core_rdata;
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic [RAM_WIDTH-1:0] dout2_d, dout2_q;
        logic                 vld2_d, vld2_q;

        always_comb begin
            dout2_d = vld1_q ? rd_data1 : dout2_q;
            vld2_d  = vld1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout2_q <= '0;
                vld2_q  <= 1'b0;
            end else begin
                dout2_q <= dout2_d;
                vld2_q  <= vld2_d;
            end
        end

        assign bus.dout       = dout2_q;
        assign bus.dout_valid = vld2_q;
    end else begin : g_lat1
        assign bus.dout       = rd_data1;
        assign bus.dout_valid = vld1_q;
    end

    assign bus.busy = busy;

endmodule

// File: tb/tb_dram_banked_rw.sv
// Directed bench driving a latency-1 and a latency-2 instance with identical stimulus.
module tb_dram_banked_rw;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_mem [16];

`ifdef DRAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    dram_banked_rw_if #(.RAM_WIDTH(32), .RAM_ADDR_WIDTH(4)) bus1 ();
    dram_banked_rw_if #(.RAM_WIDTH(32), .RAM_ADDR_WIDTH(4)) bus2 ();

    assign bus2.wen   = bus1.wen;
    assign bus2.wbe   = bus1.wbe;
    assign bus2.waddr = bus1.waddr;
    assign bus2.din   = bus1.din;
    assign bus2.ren   = bus1.ren;
    assign bus2.raddr = bus1.raddr;
    assign bus2.clear = bus1.clear;

    dram_banked_rw #(
        .RAM_WIDTH(32), .RAM_DEPTH(16), .RAM_ADDR_WIDTH(4), .RD_LATENCY(1)
    ) dut_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    dram_banked_rw #(
        .RAM_WIDTH(32), .RAM_DEPTH(16), .RAM_ADDR_WIDTH(4), .RD_LATENCY(2)
    ) dut_lat2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.wen   = 1'b0;
        bus1.wbe   = 4'h0;
        bus1.waddr = 4'h0;
        bus1.din   = 32'h0;
        bus1.ren   = 1'b0;
        bus1.raddr = 4'h0;
        bus1.clear = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus1.wen   = 1'b1;
        bus1.waddr = addr;
        bus1.din   = data;
        bus1.wbe   = be;
        tick();
        idle_inputs();
        for (int b = 0; b < 4; b++) begin
            if (be[b]) exp_mem[addr][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus1.busy, bus1.dout_valid, bus1.dout} !== 34'h0) begin
            bad++;
            $display("[TB] FAIL reset_lat1: busy/valid/dout=%h expected 0", {bus1.busy, bus1.dout_valid, bus1.dout});
        end
        total++;
        if ({bus2.busy, bus2.dout_valid, bus2.dout} !== 34'h0) begin
            bad++;
            $display("[TB] FAIL reset_lat2: busy/valid/dout=%h expected 0", {bus2.busy, bus2.dout_valid, bus2.dout});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_byte_write();
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 32'((i + 1) << 1), 4'hF);
        end
        do_write(4'd3, 32'hAABBCCDD, 4'b0101);
        bus1.ren   = 1'b1;
        bus1.raddr = 4'd3;
        tick();
        idle_inputs();
        total++;
        if ({bus1.dout_valid, bus1.dout} !== {1'b1, 32'h00BB00DD}) begin
            bad++;
            $display("[TB] FAIL byte_write_lat1: valid=%b dout=%h expected valid=1 dout=00bb00dd", bus1.dout_valid, bus1.dout);
        end
        tick();
        total++;
        if ({bus2.dout_valid, bus2.dout} !== {1'b1, 32'h00BB00DD}) begin
            bad++;
            $display("[TB] FAIL byte_write_lat2: valid=%b dout=%h expected valid=1 dout=00bb00dd", bus2.dout_valid, bus2.dout);
        end
    endtask

    task automatic test_latency();
        bus1.ren   = 1'b1;
        bus1.raddr = 4'd5;
        tick();
        idle_inputs();
        total++;
        if ({bus1.dout_valid, bus1.dout, bus2.dout_valid} !== {1'b1, 32'h0000000C, 1'b0}) begin
            bad++;
            $display("[TB] FAIL latency_cycle1: v1=%b d1=%h v2=%b expected v1=1 d1=0000000c v2=0", bus1.dout_valid, bus1.dout, bus2.dout_valid);
        end
        tick();
        total++;
        if ({bus1.dout_valid, bus1.dout} !== {1'b0, 32'h0000000C}) begin
            bad++;
            $display("[TB] FAIL latency_hold_lat1: v1=%b d1=%h expected v1=0 d1=0000000c", bus1.dout_valid, bus1.dout);
        end
        total++;
        if ({bus2.dout_valid, bus2.dout} !== {1'b1, 32'h0000000C}) begin
            bad++;
            $display("[TB] FAIL latency_cycle2: v2=%b d2=%h expected v2=1 d2=0000000c", bus2.dout_valid, bus2.dout);
        end
        tick();
        total++;
        if ({bus2.dout_valid, bus2.dout} !== {1'b0, 32'h0000000C}) begin
            bad++;
            $display("[TB] FAIL latency_hold_lat2: v2=%b d2=%h expected v2=0 d2=0000000c", bus2.dout_valid, bus2.dout);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp_full;
        logic [31:0] exp_part;
        exp_full = BYPASS ? 32'h00000055 : 32'h00000010;
        exp_part = BYPASS ? 32'h0000CCDD : 32'h00000055;
        do_write(4'd7, 32'h10, 4'hF);

        bus1.wen = 1'b1; bus1.waddr = 4'd7; bus1.din = 32'h55; bus1.wbe = 4'hF;
        bus1.ren = 1'b1; bus1.raddr = 4'd7;
        tick();
        idle_inputs();
        exp_mem[7] = 32'h55;
        total++;
        if ({bus1.dout_valid, bus1.dout} !== {1'b1, exp_full}) begin
            bad++;
            $display("[TB] FAIL same_addr_lat1: valid=%b dout=%h expected valid=1 dout=%h", bus1.dout_valid, bus1.dout, exp_full);
        end
        tick();
        total++;
        if ({bus2.dout_valid, bus2.dout} !== {1'b1, exp_full}) begin
            bad++;
            $display("[TB] FAIL same_addr_lat2: valid=%b dout=%h expected valid=1 dout=%h", bus2.dout_valid, bus2.dout, exp_full);
        end

        bus1.wen = 1'b1; bus1.waddr = 4'd7; bus1.din = 32'hAABBCCDD; bus1.wbe = 4'b0011;
        bus1.ren = 1'b1; bus1.raddr = 4'd7;
        tick();
        idle_inputs();
        exp_mem[7] = 32'h0000CCDD;
        total++;
        if ({bus1.dout_valid, bus1.dout} !== {1'b1, exp_part}) begin
            bad++;
            $display("[TB] FAIL same_addr_partial_lat1: valid=%b dout=%h expected valid=1 dout=%h", bus1.dout_valid, bus1.dout, exp_part);
        end
        tick();
        total++;
        if ({bus2.dout_valid, bus2.dout} !== {1'b1, exp_part}) begin
            bad++;
            $display("[TB] FAIL same_addr_partial_lat2: valid=%b dout=%h expected valid=1 dout=%h", bus2.dout_valid, bus2.dout, exp_part);
        end
    endtask

    task automatic test_streaming(input string tag);
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                bus1.ren   = 1'b1;
                bus1.raddr = 4'(k);
            end else begin
                bus1.ren = 1'b0;
            end
            tick();
            total++;
            if (k < 16) begin
                if ({bus1.dout_valid, bus1.dout} !== {1'b1, exp_mem[k]}) begin
                    bad++;
                    $display("[TB] FAIL %s_lat1[%0d]: valid=%b dout=%h expected valid=1 dout=%h", tag, k, bus1.dout_valid, bus1.dout, exp_mem[k]);
                end
            end else if (bus1.dout_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s_lat1_end[%0d]: valid=%b expected 0", tag, k, bus1.dout_valid);
            end
            total++;
            if (k >= 1 && k <= 16) begin
                if ({bus2.dout_valid, bus2.dout} !== {1'b1, exp_mem[k-1]}) begin
                    bad++;
                    $display("[TB] FAIL %s_lat2[%0d]: valid=%b dout=%h expected valid=1 dout=%h", tag, k - 1, bus2.dout_valid, bus2.dout, exp_mem[k-1]);
                end
            end else if (bus2.dout_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s_lat2_edge[%0d]: valid=%b expected 0", tag, k, bus2.dout_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cnt;
        bit hung;
        busy_cnt = 0;
        hung = 1'b1;
        bus1.wen = 1'b1; bus1.waddr = 4'd4; bus1.din = 32'h1234; bus1.wbe = 4'hF;
        bus1.clear = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            if (bus1.busy !== 1'b1) begin
                hung = 1'b0;
                break;
            end
            busy_cnt++;
            if (c == 8) begin
                bus1.wen = 1'b1; bus1.waddr = 4'd2; bus1.din = 32'hDEADBEEF; bus1.wbe = 4'hF;
                bus1.ren = 1'b1; bus1.raddr = 4'd9; bus1.clear = 1'b1;
            end
            tick();
            idle_inputs();
            total++;
            if ({bus1.dout_valid, bus2.dout_valid} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL clear_no_read[%0d]: valid1=%b valid2=%b expected 0 0", c, bus1.dout_valid, bus2.dout_valid);
            end
        end
        total++;
        if (hung) begin
            bad++;
            $display("[TB] FAIL clear_timeout: busy still 1 after 40 cycles, expected release after 16");
        end
        total++;
        if (busy_cnt != 16) begin
            bad++;
            $display("[TB] FAIL clear_busy_cycles: got %0d expected 16", busy_cnt);
        end
        total++;
        if (bus2.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_busy_lat2: busy=%b expected 0", bus2.busy);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        test_streaming("after_clear");
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 32'h100 + 32'(i), 4'hF);
        end
        bus1.ren = 1'b1; bus1.raddr = 4'd15;
        bus1.clear = 1'b1;
        tick();
        idle_inputs();
        repeat (8) tick();
        total++;
        if ({bus1.busy, bus1.dout, bus2.dout} !== {1'b1, 32'h10F, 32'h10F}) begin
            bad++;
            $display("[TB] FAIL mid_sweep_pre: busy=%b d1=%h d2=%h expected busy=1 d1=0000010f d2=0000010f", bus1.busy, bus1.dout, bus2.dout);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus1.busy, bus1.dout_valid, bus1.dout} !== 34'h0) begin
            bad++;
            $display("[TB] FAIL mid_sweep_reset_lat1: busy/valid/dout=%h expected 0", {bus1.busy, bus1.dout_valid, bus1.dout});
        end
        total++;
        if ({bus2.busy, bus2.dout_valid, bus2.dout} !== 34'h0) begin
            bad++;
            $display("[TB] FAIL mid_sweep_reset_lat2: busy/valid/dout=%h expected 0", {bus2.busy, bus2.dout_valid, bus2.dout});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({bus1.busy, bus2.busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL mid_sweep_idle: busy1=%b busy2=%b expected 0 0", bus1.busy, bus2.busy);
        end
        for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
        test_streaming("after_reset");
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        $display("[TB] starting, bypass=%0d", BYPASS);
        test_reset();
        test_byte_write();
        test_latency();
        test_same_addr();
        test_streaming("stream");
        test_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
